rtc_alarm_core: RTL and testbench

Parametrised timekeeping core for the digital clock: divides `mclk` down to a 1 Hz tick enable and keeps 24 h BCD time HH:MM:SS. It holds `N_ALARMS` independently enabled HH:MM alarms and drives a buzzer for a fixed number of seconds when any alarm matches. It emits a day-rollover pulse for the date logic and sits between the button/set-mode logic (upstream) and the display formatting, date and buzzer logic (downstream).

---
 rtl/rtc_alarm_core.sv | 214 +++++++++++++++++++++
 tb/tb_rtc_alarm_core.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_alarm_core.sv
// rtc_alarm_core: divides mclk to a 1 Hz second event and keeps 24 h BCD time
// HH:MM:SS. It holds N_ALARMS enable-able HH:MM alarm slots and drives a buzzer
// for RING_SECS seconds on a match. It also emits a day-rollover pulse.
// Optional feature macro: RTC_SNOOZE_EN adds a single snooze target register
// that re-rings SNOOZE_MIN minutes after a snooze pulse.
module rtc_alarm_core #(
    parameter int M_FREQ     = 20000000,
    parameter int N_ALARMS   = 4,
    parameter int RING_SECS  = 5,
    parameter int SNOOZE_MIN = 5,
    localparam int IDX_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic                run,
    input  logic                set_time_vld,
    input  logic [23:0]         set_time,
    input  logic                alm_wr,
    input  logic [IDX_W-1:0]    alm_idx,
    input  logic [15:0]         alm_time,
    input  logic                alm_en,
    input  logic                ack,
    input  logic                snooze,
    output logic [23:0]         bcd_time,
    output logic                tick,
    output logic                day_roll,
    output logic                buzzer,
    output logic [N_ALARMS-1:0] alm_hit
);

    localparam int               DIV_W     = (M_FREQ > 1) ? $clog2(M_FREQ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(M_FREQ - 1);
    localparam logic [7:0]       RING_LOAD = 8'(RING_SECS);

    logic [DIV_W-1:0]    div_cnt;
    logic [7:0]          ring_cnt;
    logic [15:0]         slot_time [N_ALARMS];
    logic [N_ALARMS-1:0] slot_en;
    logic [N_ALARMS-1:0] match_vec;
    logic [23:0]         nt;
    logic                sec_ev;
    logic                set_ok;
    logic                sec_adv;
    logic                wr_ok;
    logic                ring_start;
    logic                snz_hit;
    logic                snz_req;

    // HH:MM is valid when hours are 00..23 and minutes 00..59
    function automatic logic hm_ok(input logic [15:0] hm);
        logic ok;
        ok = (hm[15:12] <= 4'd2) && (hm[11:8] <= 4'd9) &&
             (hm[7:4] <= 4'd5) && (hm[3:0] <= 4'd9);
        if ((hm[15:12] == 4'd2) && (hm[11:8] > 4'd3))
            ok = 1'b0;
        return ok;
    endfunction

    function automatic logic time_ok(input logic [23:0] t);
        return hm_ok(t[23:8]) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

    // One-second BCD increment with ripple carry through all six digits
    function automatic logic [23:0] next_time(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        {h1, h0, m1, m0, s1, s0} = t;
        if (s0 != 4'd9) begin
            s0 = s0 + 4'd1;
        end else begin
            s0 = 4'd0;
            if (s1 != 4'd5) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (m0 != 4'd9) begin
                    m0 = m0 + 4'd1;
                end else begin
                    m0 = 4'd0;
                    if (m1 != 4'd5) begin
                        m1 = m1 + 4'd1;
                    end else begin
                        m1 = 4'd0;
                        if ((h1 == 4'd2) && (h0 == 4'd3)) begin
                            h1 = 4'd0;
                            h0 = 4'd0;
                        end else if (h0 != 4'd9) begin
                            h0 = h0 + 4'd1;
                        end else begin
                            h0 = 4'd0;
                            h1 = h1 + 4'd1;
                        end
                    end
                end
            end
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

`ifdef RTC_SNOOZE_EN
    logic        snz_arm;
    logic [15:0] snz_time;

    // HH:MM + SNOOZE_MIN with carry into hours and wrap at 24 h
    function automatic logic [15:0] snooze_target(input logic [15:0] hm);
        int h;
        int m;
        h = int'(hm[15:12]) * 10 + int'(hm[11:8]);
        m = int'(hm[7:4]) * 10 + int'(hm[3:0]) + SNOOZE_MIN;
        if (m >= 60) begin
            m = m - 60;
            h = h + 1;
        end
        if (h >= 24)
            h = h - 24;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    assign snz_req = snooze && buzzer;
    assign snz_hit = sec_adv && snz_arm && (nt[7:0] == 8'h00) && (nt[23:8] == snz_time);

    // Single snooze target: armed by a snooze while ringing, consumed when it rings or on ack
    always_ff @(posedge mclk) begin
        if (rst) begin
            snz_arm  <= 1'b0;
            snz_time <= 16'h0000;
        end else if (ack || snz_hit) begin
            snz_arm <= 1'b0;
        end else if (snz_req && !ring_start) begin
            snz_arm  <= 1'b1;
            snz_time <= snooze_target(bcd_time[23:8]);
        end
    end
`else
    logic unused_snooze;

    assign snz_req       = 1'b0;
    assign snz_hit       = 1'b0;
    assign unused_snooze = snooze ^ SNOOZE_MIN[0];
`endif

    // Second event, load/write qualification and alarm compare on the next time value
    always_comb begin
        sec_ev    = run && (div_cnt == DIV_LAST);
        set_ok    = set_time_vld && time_ok(set_time);
        sec_adv   = sec_ev && !set_ok;
        nt        = next_time(bcd_time);
        wr_ok     = alm_wr && hm_ok(alm_time) && (int'(alm_idx) < N_ALARMS);
        match_vec = '0;
        for (int i = 0; i < N_ALARMS; i++)
            match_vec[i] = sec_adv && slot_en[i] && (nt[7:0] == 8'h00) &&
                           (slot_time[i] == nt[23:8]);
        ring_start = (|match_vec) || snz_hit;
    end

    // Divider and time-of-day; a valid load wins over a coincident second event
    always_ff @(posedge mclk) begin
        if (rst) begin
            div_cnt  <= '0;
            bcd_time <= 24'h000000;
            tick     <= 1'b0;
            day_roll <= 1'b0;
        end else begin
            if (set_ok || sec_ev)
                div_cnt <= '0;
            else if (run)
                div_cnt <= div_cnt + DIV_W'(1);

            if (set_ok)
                bcd_time <= set_time;
            else if (sec_adv)
                bcd_time <= nt;

            tick     <= sec_adv;
            day_roll <= sec_adv && (bcd_time == 24'h235959);
        end
    end

    // Alarm slot storage; invalid times are dropped
    always_ff @(posedge mclk) begin
        if (rst) begin
            slot_en <= '0;
            for (int i = 0; i < N_ALARMS; i++)
                slot_time[i] <= 16'h0000;
        end else if (wr_ok) begin
            slot_en[alm_idx]   <= alm_en;
            slot_time[alm_idx] <= alm_time;
        end
    end

    // Ring control: a match beats ack, ack beats snooze, otherwise count down per second
    always_ff @(posedge mclk) begin
        if (rst) begin
            buzzer   <= 1'b0;
            ring_cnt <= 8'd0;
            alm_hit  <= '0;
        end else if (ring_start) begin
            buzzer   <= 1'b1;
            ring_cnt <= RING_LOAD;
            alm_hit  <= (ack ? {N_ALARMS{1'b0}} : alm_hit) | match_vec;
        end else if (ack) begin
            buzzer   <= 1'b0;
            ring_cnt <= 8'd0;
            alm_hit  <= '0;
        end else if (snz_req) begin
            buzzer   <= 1'b0;
            ring_cnt <= 8'd0;
        end else if (sec_adv && (ring_cnt != 8'd0)) begin
            ring_cnt <= ring_cnt - 8'd1;
            if (ring_cnt == 8'd1)
                buzzer <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rtc_alarm_core.sv
// Scoreboard bench for rtc_alarm_core with M_FREQ=4: a seconds-of-day model
// predicts each tick's outputs, which are queued when stimulus is issued and
// compared when the DUT pulses tick.
module tb_rtc_alarm_core;

    localparam int MF    = 4;
    localparam int NA    = 4;
    localparam int RING  = 5;
    localparam int SNZ   = 5;

    logic        mclk = 1'b0;
    logic        rst;
    logic        run;
    logic        set_time_vld;
    logic [23:0] set_time;
    logic        alm_wr;
    logic [1:0]  alm_idx;
    logic [15:0] alm_time;
    logic        alm_en;
    logic        ack;
    logic        snooze;
    logic [23:0] bcd_time;
    logic        tick;
    logic        day_roll;
    logic        buzzer;
    logic [3:0]  alm_hit;

    typedef struct packed {
        logic [23:0] t;
        logic        dr;
        logic        bz;
        logic [3:0]  hit;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_tick_cyc = 0;

    // reference model state
    int       m_sec;
    int       m_alm [NA];
    bit       m_en  [NA];
    int       m_ring;
    bit       m_buz;
    bit [3:0] m_hit;
    bit       m_snz_arm;
    int       m_snz;

    rtc_alarm_core #(
        .M_FREQ     (MF),
        .N_ALARMS   (NA),
        .RING_SECS  (RING),
        .SNOOZE_MIN (SNZ)
    ) dut (
        .mclk         (mclk),
        .rst          (rst),
        .run          (run),
        .set_time_vld (set_time_vld),
        .set_time     (set_time),
        .alm_wr       (alm_wr),
        .alm_idx      (alm_idx),
        .alm_time     (alm_time),
        .alm_en       (alm_en),
        .ack          (ack),
        .snooze       (snooze),
        .bcd_time     (bcd_time),
        .tick         (tick),
        .day_roll     (day_roll),
        .buzzer       (buzzer),
        .alm_hit      (alm_hit)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int bcd_to_sec(input logic [23:0] v);
        return (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
               (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
               int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic int bcd_to_min(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
               int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    // Advance the model by one second and queue the expected tick outputs
    task automatic model_tick();
        bit [3:0] mv;
        bit       sh;
        m_sec = (m_sec + 1) % 86400;
        mv = '0;
        sh = 1'b0;
        if (m_sec % 60 == 0) begin
            for (int i = 0; i < NA; i++)
                if (m_en[i] && m_alm[i] == m_sec / 60) mv[i] = 1'b1;
            if (m_snz_arm && m_snz == m_sec / 60) sh = 1'b1;
        end
        if (mv != 0 || sh) begin
            m_buz  = 1'b1;
            m_ring = RING;
            m_hit  = m_hit | mv;
            if (sh) m_snz_arm = 1'b0;
        end else if (m_ring > 0) begin
            m_ring--;
            if (m_ring == 0) m_buz = 1'b0;
        end
        sb_q.push_back('{t: to_bcd(m_sec), dr: (m_sec == 0), bz: m_buz, hit: m_hit});
    endtask

    task automatic model_ack();
        m_buz = 1'b0;
        m_ring = 0;
        m_hit = '0;
        m_snz_arm = 1'b0;
    endtask

    task automatic model_reset();
        m_sec = 0;
        m_ring = 0;
        m_buz = 1'b0;
        m_hit = '0;
        m_snz_arm = 1'b0;
        m_snz = 0;
        for (int i = 0; i < NA; i++) begin
            m_alm[i] = 0;
            m_en[i]  = 1'b0;
        end
    endtask

    // Monitor: every tick pops one expected entry; day_roll must never appear without tick
    always @(negedge mclk) begin
        if (tick === 1'b1) begin
            last_tick_cyc = cyc;
            if (sb_q.size() == 0) begin
                chk("tick_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("tick_time",  bcd_time, mon_e.t);
                chk("tick_droll", day_roll, mon_e.dr);
                chk("tick_buz",   buzzer,   mon_e.bz);
                chk("tick_hit",   alm_hit,  mon_e.hit);
            end
        end else if (day_roll !== 1'b0) begin
            chk("droll_without_tick", day_roll, 32'd0);
        end
    end

    task automatic wait_empty(input int bound);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            @(negedge mclk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("sb_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) model_tick();
        wait_empty(n * MF + 4 * MF);
    endtask

    task automatic set_t(input logic [23:0] v, input bit valid);
        set_time = v;
        set_time_vld = 1'b1;
        @(posedge mclk);
        #1 set_time_vld = 1'b0;
        if (valid) m_sec = bcd_to_sec(v);
        @(negedge mclk);
        #1;
        chk("set_load", bcd_time, to_bcd(m_sec));
    endtask

    task automatic alm_write(input int idx, input logic [15:0] v, input bit en, input bit valid);
        alm_idx = 2'(idx);
        alm_time = v;
        alm_en = en;
        alm_wr = 1'b1;
        @(posedge mclk);
        #1 alm_wr = 1'b0;
        if (valid) begin
            m_alm[idx] = bcd_to_min(v);
            m_en[idx]  = en;
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(posedge mclk);
        #1 ack = 1'b0;
        model_ack();
        @(negedge mclk);
        #1;
        chk("ack_buz", buzzer, m_buz);
        chk("ack_hit", alm_hit, m_hit);
    endtask

    task automatic snooze_pulse();
        snooze = 1'b1;
        @(posedge mclk);
        #1 snooze = 1'b0;
`ifdef RTC_SNOOZE_EN
        if (m_buz) begin
            m_buz = 1'b0;
            m_ring = 0;
            m_snz_arm = 1'b1;
            m_snz = (m_sec / 60 + SNZ) % 1440;
        end
`endif
        @(negedge mclk);
        #1;
        chk("snooze_buz", buzzer, m_buz);
        chk("snooze_hit", alm_hit, m_hit);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        rst = 1'b1;
        run = 1'b0;
        set_time_vld = 1'b0;
        set_time = '0;
        alm_wr = 1'b0;
        alm_idx = '0;
        alm_time = '0;
        alm_en = 1'b0;
        ack = 1'b0;
        snooze = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        #1;
        chk("rst_time", bcd_time, 24'h000000);
        chk("rst_tick", tick, 1'b0);
        chk("rst_droll", day_roll, 1'b0);
        chk("rst_buz", buzzer, 1'b0);
        chk("rst_hit", alm_hit, 4'h0);

        // free run: 000001 .. 000101, tick every MF cycles
        rst = 1'b0;
        run = 1'b1;
        advance(1);
        t0 = last_tick_cyc;
        advance(60);
        chk("tick_period", last_tick_cyc - t0, 60 * MF);

        // midnight rollover
        set_t(24'h235958, 1'b1);
        advance(2);

        // invalid loads ignored, valid load restarts the divider
        set_t(24'h250000, 1'b0);
        set_t(24'h126000, 1'b0);
        set_t(24'h235959, 1'b1);
        model_tick();
        n = 0;
        while (n < 3 * MF) begin
            @(negedge mclk);
            n++;
            if (tick === 1'b1) break;
        end
        chk("set_to_tick", n, MF);
        #1;
        wait_empty(8 * MF);

        // alarms 0 and 2 at 0700 enabled, 1 disabled, 3 at 0701 with an invalid rewrite
        run = 1'b0;
        alm_write(0, 16'h0700, 1'b1, 1'b1);
        alm_write(1, 16'h0700, 1'b0, 1'b1);
        alm_write(2, 16'h0700, 1'b1, 1'b1);
        alm_write(3, 16'h0701, 1'b1, 1'b1);
        alm_write(3, 16'h0760, 1'b1, 1'b0);
        alm_write(2, 16'h0A00, 1'b0, 1'b0);
        set_t(24'h065958, 1'b1);
        run = 1'b1;
        advance(8);
        ack_pulse();

        // ack mid-ring
        set_t(24'h065958, 1'b1);
        advance(4);
        ack_pulse();

        // loading a matching time does not ring
        set_t(24'h070000, 1'b1);
        chk("load_no_ring", buzzer, 1'b0);
        advance(1);

        // ack coincident with the 070100 match: the match wins
        run = 1'b0;
        set_t(24'h070059, 1'b1);
        run = 1'b1;
        repeat (3) @(posedge mclk);
        #1 ack = 1'b1;
        model_ack();
        model_tick();
        @(posedge mclk);
        #1 ack = 1'b0;
        wait_empty(4 * MF);

        // disabling the slot while ringing does not stop the current ring
        alm_write(3, 16'h0701, 1'b0, 1'b1);
        advance(6);
        ack_pulse();

        // snooze at 235801 on the 2358 alarm
        run = 1'b0;
        alm_write(0, 16'h2358, 1'b1, 1'b1);
        set_t(24'h235758, 1'b1);
        run = 1'b1;
        advance(2);
        advance(1);
        snooze_pulse();
`ifdef RTC_SNOOZE_EN
        advance(299);
`else
        advance(6);
`endif
        ack_pulse();

        // reset mid-ring and mid-divide, then slots must be cleared
        set_t(24'h065958, 1'b1);
        advance(3);
        chk("pre_rst_buz", buzzer, 1'b1);
        rst = 1'b1;
        @(posedge mclk);
        #1;
        @(negedge mclk);
        #1;
        model_reset();
        chk("rst2_time", bcd_time, 24'h000000);
        chk("rst2_tick", tick, 1'b0);
        chk("rst2_droll", day_roll, 1'b0);
        chk("rst2_buz", buzzer, 1'b0);
        chk("rst2_hit", alm_hit, 4'h0);
        rst = 1'b0;
        set_t(24'h065958, 1'b1);
        advance(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
